// File: rtl/traffic_pkg.sv
// Shared state encodings, lamp constants and the lamp decode for the
// main/side intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_WALK = 3'd2,
    S_SG   = 3'd3,
    S_SY   = 3'd4
  } state_t;

  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
  } lamps_t;

  // Unknown encodings show the reset aspect so the heads never go dark or conflict.
  function automatic lamps_t decode_lamps(input state_t st);
    lamps_t l;
    l.main = LT_R;
    l.side = LT_R;
    l.walk = 1'b0;
    case (st)
      S_MG:    l.main = LT_G;
      S_MY:    l.main = LT_Y;
      S_WALK:  l.walk = 1'b1;
      S_SG:    l.side = LT_G;
      S_SY:    l.side = LT_Y;
      default: l.main = LT_G;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter; expire marks the tick on which the current
// interval is used up, so an interval of N lasts exactly N ticks.
module interval_timer #(
  parameter int            TW      = 4,
  parameter logic [TW-1:0] RST_VAL = {TW{1'b0}}
) (
  input  logic          clk,
  input  logic          g_reset,
  input  logic          tick,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);

  logic [TW-1:0] count_r;

  assign expire = tick && (count_r == {{(TW-1){1'b0}}, 1'b1});

  // Count register: a load wins over the tick decrement.
  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      count_r <= RST_VAL;
    end else if (load) begin
      count_r <= load_val;
    end else if (tick) begin
      count_r <= count_r - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side intersection controller with walk phase and one side-green
// extension; lamp outputs are registered copies of the next-state decode.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2,
  parameter int TW     = 4
) (
  input  logic       clk,
  input  logic       g_reset,
  input  logic       tick,
  input  logic       Sensor_Sync,
  input  logic       WR,
  output logic       WR_Reset,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_lamp,
  output logic [2:0] state_out
);

  localparam logic [TW-1:0] IV_BASE = TW'(T_BASE);
  localparam logic [TW-1:0] IV_EXT  = TW'(T_EXT);
  localparam logic [TW-1:0] IV_YEL  = TW'(T_YEL);

  state_t        state_r;
  state_t        state_next_s;
  logic          sg_ext_r;
  logic          sg_ext_next_s;
  logic          load_s;
  logic [TW-1:0] load_val_s;
  logic          expire_s;
  lamps_t        lamps_next_s;
  logic [2:0]    main_light_r;
  logic [2:0]    side_light_r;
  logic          walk_lamp_r;
  logic          wr_reset_r;

  interval_timer #(
    .TW      (TW),
    .RST_VAL (IV_BASE)
  ) u_timer (
    .clk      (clk),
    .g_reset  (g_reset),
    .tick     (tick),
    .load     (load_s),
    .load_val (load_val_s),
    .expire   (expire_s)
  );

  // Next-state, extension flag and timer reload; inputs matter only on expire.
  always_comb begin
    state_next_s  = state_r;
    sg_ext_next_s = sg_ext_r;
    load_s        = 1'b0;
    load_val_s    = IV_BASE;
    case (state_r)
      S_MG: begin
        if (expire_s) begin
          load_s = 1'b1;
          if (WR || Sensor_Sync) begin
            state_next_s = S_MY;
            load_val_s   = IV_YEL;
          end else begin
            load_val_s = IV_BASE;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      S_MY: begin
        if (expire_s) begin
          load_s = 1'b1;
          if (WR) begin
            state_next_s = S_WALK;
            load_val_s   = IV_EXT;
          end else begin
            state_next_s  = S_SG;
            load_val_s    = IV_BASE;
            sg_ext_next_s = 1'b0;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      S_WALK: begin
        if (expire_s) begin
          load_s     = 1'b1;
          load_val_s = IV_BASE;
          if (Sensor_Sync) begin
            state_next_s  = S_SG;
            sg_ext_next_s = 1'b0;
          end else begin
            state_next_s = S_MG;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      S_SG: begin
        if (expire_s) begin
          load_s = 1'b1;
          if (Sensor_Sync && !sg_ext_r) begin
            load_val_s    = IV_EXT;
            sg_ext_next_s = 1'b1;
          end else begin
            state_next_s = S_SY;
            load_val_s   = IV_YEL;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      S_SY: begin
        if (expire_s) begin
          load_s       = 1'b1;
          state_next_s = S_MG;
          load_val_s   = IV_BASE;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_next_s  = S_MG;
        sg_ext_next_s = 1'b0;
        load_s        = 1'b1;
        load_val_s    = IV_BASE;
      end
    endcase
    lamps_next_s = decode_lamps(state_next_s);
  end

  // State, extension flag and registered lamp/pulse outputs.
  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      state_r      <= S_MG;
      sg_ext_r     <= 1'b0;
      main_light_r <= LT_G;
      side_light_r <= LT_R;
      walk_lamp_r  <= 1'b0;
      wr_reset_r   <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      sg_ext_r     <= sg_ext_next_s;
      main_light_r <= lamps_next_s.main;
      side_light_r <= lamps_next_s.side;
      walk_lamp_r  <= lamps_next_s.walk;
      wr_reset_r   <= (state_next_s == S_WALK) && (state_r != S_WALK);
    end
  end

  assign WR_Reset   = wr_reset_r;
  assign main_light = main_light_r;
  assign side_light = side_light_r;
  assign walk_lamp  = walk_lamp_r;
  assign state_out  = state_r;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench: stimulus drives a phase/tick-count reference model and
// queues expected outputs; a monitor pops and compares after each edge.
module tb_traffic_light_fsm;

  localparam int T_BASE = 6;
  localparam int T_EXT  = 3;
  localparam int T_YEL  = 2;
  localparam int TW     = 4;

  localparam int P_MG = 0, P_MY = 1, P_WALK = 2, P_SG = 3, P_SY = 4;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
    logic       wrr;
  } exp_t;

  logic       clk = 1'b0;
  logic       g_reset = 1'b1;
  logic       tick = 1'b0;
  logic       sensor = 1'b0;
  logic       wr_reg = 1'b0;
  logic       wr_reset_o;
  logic [2:0] main_o, side_o, state_o;
  logic       walk_o;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  int m_phase = P_MG;
  int m_left  = T_BASE;
  bit m_ext   = 1'b0;
  bit m_pulse = 1'b0;

  traffic_light_fsm #(.T_BASE(T_BASE), .T_EXT(T_EXT), .T_YEL(T_YEL), .TW(TW)) dut (
    .clk         (clk),
    .g_reset     (g_reset),
    .tick        (tick),
    .Sensor_Sync (sensor),
    .WR          (wr_reg),
    .WR_Reset    (wr_reset_o),
    .main_light  (main_o),
    .side_light  (side_o),
    .walk_lamp   (walk_o),
    .state_out   (state_o)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int p);
    case (p)
      P_MY, P_SY: return T_YEL;
      P_WALK:     return T_EXT;
      default:    return T_BASE;
    endcase
  endfunction

  task automatic model_goto(input int p);
    m_phase = p;
    m_left  = dur(p);
    if (p == P_SG) m_ext = 1'b0;
    m_pulse = (p == P_WALK);
  endtask

  // One clock of the reference: a tick spends one unit of the phase budget.
  task automatic model_step(input bit rst, input bit t, input bit wr, input bit sn);
    m_pulse = 1'b0;
    if (rst) begin
      m_phase = P_MG;
      m_left  = T_BASE;
      m_ext   = 1'b0;
    end else if (t) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        case (m_phase)
          P_MG:   if (wr || sn) model_goto(P_MY); else m_left = T_BASE;
          P_MY:   if (wr) model_goto(P_WALK); else model_goto(P_SG);
          P_WALK: if (sn) model_goto(P_SG); else model_goto(P_MG);
          P_SG: begin
            if (sn && !m_ext) begin
              m_left = T_EXT;
              m_ext  = 1'b1;
            end else begin
              model_goto(P_SY);
            end
          end
          default: model_goto(P_MG);
        endcase
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.st   = 3'(m_phase);
    e.main = (m_phase == P_MG) ? G : (m_phase == P_MY) ? Y : R;
    e.side = (m_phase == P_SG) ? G : (m_phase == P_SY) ? Y : R;
    e.walk = (m_phase == P_WALK);
    e.wrr  = m_pulse;
    q.push_back(e);
  endtask

  // Drive one cycle from a negedge; the walk register latches req until WR_Reset.
  task automatic step(input bit t, input bit sn, input bit req);
    if (wr_reset_o === 1'b1) wr_reg = 1'b0;
    if (req) wr_reg = 1'b1;
    tick   = t;
    sensor = sn;
    model_step(g_reset, t, wr_reg, sn);
    push_exp();
    @(negedge clk);
  endtask

  task automatic pulse_reset(input int n);
    m_phase = P_MG; m_left = T_BASE; m_ext = 1'b0; m_pulse = 1'b0;
    push_exp();
    wr_reg  = 1'b0;
    g_reset = 1'b1;
    repeat (n) step(1'b1, 1'b0, 1'b0);
    g_reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: compares after every clock edge and after an asynchronous reset.
  initial begin
    exp_t e;
    #2;
    forever begin
      @(posedge clk or posedge g_reset);
      #1;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue expected an entry", $time);
      end else begin
        e = q.pop_front();
        chk("state_out", state_o, e.st);
        chk("main_light", main_o, e.main);
        chk("side_light", side_o, e.side);
        chk("walk_lamp", {2'b00, walk_o}, {2'b00, e.walk});
        chk("WR_Reset", {2'b00, wr_reset_o}, {2'b00, e.wrr});
      end
    end
  end

  initial begin
    int guard;
    // Reset, then idle: main green forever, no WR_Reset.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    g_reset = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

    // Sensor held: MG, MY, SG with one extension, SY, MG.
    pulse_reset(2);
    for (int i = 0; i < 26; i++) step(1'b1, 1'b1, 1'b0);

    // Walk request at cycle 3.
    pulse_reset(2);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, i == 2);

    // Walk request and sensor together.
    pulse_reset(2);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, i == 1);

    // Tick every 4th cycle.
    pulse_reset(2);
    for (int i = 0; i < 120; i++) step((i % 4) == 3, 1'b1, i == 40);

    // Reset in the middle of the walk phase.
    pulse_reset(2);
    guard = 0;
    step(1'b1, 1'b0, 1'b1);
    while (m_phase != P_WALK && guard < 40) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    n_checks++;
    if (m_phase != P_WALK) begin
      n_fail++;
      $display("FAIL reach_walk: got phase %0d expected %0d", m_phase, P_WALK);
    end
    step(1'b1, 1'b0, 1'b0);
    pulse_reset(2);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);

    // Random traffic with sparse ticks, requests and occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset(1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
